rca_pipe: RTL and testbench



---
 rtl/rca_pipe.sv | 138 +++++++++++++
 tb/tb_rca_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rca_pipe.sv
// rca_pipe: pipelined ripple-carry adder/subtractor. Each stage ripples one CHUNK-bit slice.
// Valid/ready handshake with full backpressure. Define RCA_PIPE_OVF_EN to add the ovf output.
module rca_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef RCA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CHUNK = WIDTH / STAGES;

    if ((WIDTH < 2) || (STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("rca_pipe: WIDTH must be >= 2 and a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic [STAGES-1:0] v_s;
    logic [STAGES-1:0] rdy_s;
    logic              full_s;

    // Stage k may load unless it and every stage after it are occupied and the sink stalls
    always_comb begin
        full_s = 1'b1;
        rdy_s  = {STAGES{1'b0}};
        for (int k = STAGES - 1; k >= 0; k--) begin
            full_s   = full_s & v_s[k];
            rdy_s[k] = out_ready | ~full_s;
        end
    end

    assign in_ready = rdy_s[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = WIDTH - k * CHUNK;
        localparam int RW = (k + 1) * CHUNK;

        logic           vin_s;
        logic           cin_s;
        logic [IW-1:0]  ain_s;
        logic [IW-1:0]  bin_s;
        logic [RW-1:0]  rnx_s;
        logic [CHUNK:0] part_s;
        logic           ld_s;
        logic           v_r;
        logic           c_r;
        logic [RW-1:0]  res_r;

        assign part_s = {1'b0, ain_s[CHUNK-1:0]} + {1'b0, bin_s[CHUNK-1:0]} + {{CHUNK{1'b0}}, cin_s};
        assign ld_s   = rdy_s[k] & vin_s;
        assign v_s[k] = v_r;

        if (k == 0) begin : g_src
            assign vin_s = in_valid;
            assign ain_s = a;
            assign bin_s = b ^ {WIDTH{sub}};
            assign cin_s = cin ^ sub;
            assign rnx_s = part_s[CHUNK-1:0];
        end else begin : g_src
            assign vin_s = g_stage[k-1].v_r;
            assign ain_s = g_stage[k-1].g_ops.a_r;
            assign bin_s = g_stage[k-1].g_ops.b_r;
            assign cin_s = g_stage[k-1].c_r;
            assign rnx_s = {part_s[CHUNK-1:0], g_stage[k-1].res_r};
        end

        // Stage valid tracks the upstream valid whenever this slot may load
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r <= 1'b0;
            end else if (rdy_s[k]) begin
                v_r <= vin_s;
            end
        end

        // Result bits and chunk carry move only with a real beat, so an idle output holds
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_r <= {RW{1'b0}};
                c_r   <= 1'b0;
            end else if (ld_s) begin
                res_r <= rnx_s;
                c_r   <= part_s[CHUNK];
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [IW-CHUNK-1:0] a_r;
            logic [IW-CHUNK-1:0] b_r;

            // Carry the still-unprocessed operand chunks forward with their beat
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= {(IW - CHUNK){1'b0}};
                    b_r <= {(IW - CHUNK){1'b0}};
                end else if (ld_s) begin
                    a_r <= ain_s[IW-1:CHUNK];
                    b_r <= bin_s[IW-1:CHUNK];
                end
            end
        end

`ifdef RCA_PIPE_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_r;

            // Carry into the MSB is recovered as sum ^ a ^ b at that bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_r <= 1'b0;
                end else if (ld_s) begin
                    ovf_r <= part_s[CHUNK] ^ part_s[CHUNK-1] ^ ain_s[CHUNK-1] ^ bin_s[CHUNK-1];
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].v_r;
    assign sum       = g_stage[STAGES-1].res_r;
    assign cout      = g_stage[STAGES-1].c_r;
`ifdef RCA_PIPE_OVF_EN
    assign ovf       = g_stage[STAGES-1].g_ovf.ovf_r;
`endif

endmodule

// File: tb/tb_rca_pipe.sv
// Directed self-checking bench for rca_pipe: an 8-bit/2-stage instance and a 12-bit/3-stage instance.
module tb_rca_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [7:0]  a, b, sum;
    logic        w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_out_ready, w_cout;
    logic [11:0] w_a, w_b, w_sum;
`ifdef RCA_PIPE_OVF_EN
    logic        ovf, w_ovf;
`endif
    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] bb_a   [4] = '{8'd1, 8'd2, 8'd3, 8'd255};
    logic [7:0] bb_b   [4] = '{8'd1, 8'd2, 8'd3, 8'd1};
    logic [7:0] bb_sum [4] = '{8'd2, 8'd4, 8'd6, 8'd0};
    logic       bb_c   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    rca_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef RCA_PIPE_OVF_EN
        , .ovf(ovf)
`endif
    );

    rca_pipe #(.WIDTH(12), .STAGES(3)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .sub(w_sub), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .sum(w_sum), .cout(w_cout)
`ifdef RCA_PIPE_OVF_EN
        , .ovf(w_ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat through the 8-bit pipe with out_ready=1; leaves the result on the output
    task automatic do_one(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                          input logic xcin, input logic xsub, input logic [7:0] esum, input logic ecout);
        a = xa; b = xb; cin = xcin; sub = xsub; in_valid = 1'b1;
        #1 chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk({tag, ".latency"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".sum"}, 32'(sum), 32'(esum));
        chk({tag, ".cout"}, 32'(cout), 32'(ecout));
    endtask

    // One beat through the 12-bit, 3-stage pipe
    task automatic do_w(input string tag, input logic [11:0] xa, input logic [11:0] xb,
                        input logic xcin, input logic xsub, input logic [11:0] esum, input logic ecout);
        w_a = xa; w_b = xb; w_cin = xcin; w_sub = xsub; w_in_valid = 1'b1;
        #1 chk({tag, ".in_ready"}, 32'(w_in_ready), 32'd1);
        tick();
        w_in_valid = 1'b0;
        chk({tag, ".lat1"}, 32'(w_out_valid), 32'd0);
        tick();
        chk({tag, ".lat2"}, 32'(w_out_valid), 32'd0);
        tick();
        chk({tag, ".valid"}, 32'(w_out_valid), 32'd1);
        chk({tag, ".sum"}, 32'(w_sum), 32'(esum));
        chk({tag, ".cout"}, 32'(w_cout), 32'(ecout));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = 8'd0; b = 8'd0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_a = 12'd0; w_b = 12'd0; w_cin = 1'b0; w_sub = 1'b0; w_out_ready = 1'b1;
        #2;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.sum", 32'(sum), 32'd0);
        chk("rst.cout", 32'(cout), 32'd0);
        chk("rst.w_out_valid", 32'(w_out_valid), 32'd0);
`ifdef RCA_PIPE_OVF_EN
        chk("rst.ovf", 32'(ovf), 32'd0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        #1 chk("rst.in_ready", 32'(in_ready), 32'd1);

        // Single beats: add/sub, carry across the chunk boundary, borrow cases
        do_one("add200_100", 8'd200, 8'd100, 1'b0, 1'b0, 8'd44, 1'b1);
        do_one("sub5_7", 8'd5, 8'd7, 1'b0, 1'b1, 8'd254, 1'b0);
        do_one("sub7_5_c1", 8'd7, 8'd5, 1'b1, 1'b1, 8'd1, 1'b1);
        do_one("add15_1", 8'd15, 8'd1, 1'b0, 1'b0, 8'd16, 1'b0);
        do_one("add255_c1", 8'd255, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1);
        do_one("sub0_0", 8'd0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b1);

        // Back-to-back stream at full throughput
        in_valid = 1'b1; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = bb_a[i]; b = bb_b[i];
            #1 chk("b2b.in_ready", 32'(in_ready), 32'd1);
            tick();
            if (i == 0) begin
                chk("b2b.first_latency", 32'(out_valid), 32'd0);
            end else begin
                chk("b2b.valid", 32'(out_valid), 32'd1);
                chk("b2b.sum", 32'(sum), 32'(bb_sum[i-1]));
                chk("b2b.cout", 32'(cout), 32'(bb_c[i-1]));
            end
        end
        in_valid = 1'b0;
        tick();
        chk("b2b.last_valid", 32'(out_valid), 32'd1);
        chk("b2b.last_sum", 32'(sum), 32'(bb_sum[3]));
        chk("b2b.last_cout", 32'(cout), 32'(bb_c[3]));
        tick();
        chk("b2b.drained", 32'(out_valid), 32'd0);

        // Backpressure: two beats fill the pipe, the third waits
        out_ready = 1'b0; in_valid = 1'b1; a = 8'd10; b = 8'd1;
        #1 chk("bp.rdy1", 32'(in_ready), 32'd1);
        tick();
        chk("bp.v_after1", 32'(out_valid), 32'd0);
        a = 8'd20; b = 8'd2;
        #1 chk("bp.rdy2", 32'(in_ready), 32'd1);
        tick();
        chk("bp.valid", 32'(out_valid), 32'd1);
        chk("bp.sum_first", 32'(sum), 32'd11);
        chk("bp.full", 32'(in_ready), 32'd0);
        a = 8'd30; b = 8'd3;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bp.hold_sum", 32'(sum), 32'd11);
            chk("bp.hold_valid", 32'(out_valid), 32'd1);
            chk("bp.hold_full", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1 chk("bp.release_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp.sum_second", 32'(sum), 32'd22);
        tick();
        chk("bp.sum_third", 32'(sum), 32'd33);
        chk("bp.valid_third", 32'(out_valid), 32'd1);
        tick();
        chk("bp.no_dup", 32'(out_valid), 32'd0);

        // Reset with two beats in flight
        out_ready = 1'b0; in_valid = 1'b1; a = 8'd200; b = 8'd100;
        tick();
        a = 8'd250; b = 8'd10;
        tick();
        in_valid = 1'b0;
        chk("mid.pre_sum", 32'(sum), 32'd44);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.out_valid", 32'(out_valid), 32'd0);
        chk("mid.sum", 32'(sum), 32'd0);
        chk("mid.cout", 32'(cout), 32'd0);
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        #1 chk("mid.in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid.no_stale", 32'(out_valid), 32'd0);
        end

        // Wider, deeper instance
        do_w("w_add4095_1", 12'd4095, 12'd1, 1'b0, 1'b0, 12'd0, 1'b1);
        do_w("w_sub256_1", 12'd256, 12'd1, 1'b0, 1'b1, 12'd255, 1'b1);
        do_w("w_sub1_2", 12'd1, 12'd2, 1'b0, 1'b1, 12'd4095, 1'b0);

`ifdef RCA_PIPE_OVF_EN
        do_one("ovf100_100", 8'd100, 8'd100, 1'b0, 1'b0, 8'd200, 1'b0);
        chk("ovf100_100.ovf", 32'(ovf), 32'd1);
        do_one("ovf100_20", 8'd100, 8'd20, 1'b0, 1'b0, 8'd120, 1'b0);
        chk("ovf100_20.ovf", 32'(ovf), 32'd0);
        do_one("ovf128_1", 8'd128, 8'd1, 1'b0, 1'b1, 8'd127, 1'b1);
        chk("ovf128_1.ovf", 32'(ovf), 32'd1);
        do_w("w_ovf4095_1", 12'd4095, 12'd1, 1'b0, 1'b0, 12'd0, 1'b1);
        chk("w_ovf4095_1.ovf", 32'(w_ovf), 32'd0);
        do_w("w_ovf2047_1", 12'd2047, 12'd1, 1'b0, 1'b0, 12'd2048, 1'b0);
        chk("w_ovf2047_1.ovf", 32'(w_ovf), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
